// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle CPU control sequencer.
// Holds the supported opcode constants, the 4-bit state encodings, the
// datapath mux/ALU encodings, and the bundled control-word struct that the
// state decoder hands to the top level.
package multicycle_control_pkg;

  // Opcode field values of the supported instructions
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // Sequencer states; encodings are visible on state_o and must not change
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MADDR  = 4'd2,
    ST_MREAD  = 4'd3,
    ST_MWB    = 4'd4,
    ST_MWRITE = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9,
    ST_IEXEC  = 4'd10,
    ST_IWB    = 4'd11,
    ST_TRAP   = 4'd12
  } state_e;

  // ALU B operand select
  localparam logic [1:0] SRCB_REG_B   = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALU operation request to ALUControl
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Next-PC select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Full set of datapath controls produced for one state
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

  // States whose exit always retires an instruction (MWRITE is handled
  // separately because its exit depends on the memory handshake).
  function automatic logic retires_on_exit(input state_e st);
    return (st == ST_MWB) || (st == ST_RWB) || (st == ST_BRANCH) ||
           (st == ST_JUMP) || (st == ST_IWB);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// Pure-combinational state-to-controls decoder for multicycle_control.
// Ports:
//   state_i     current sequencer state encoding
//   mem_ready_i shared-memory ready; only gates irWrite/pcWrite in FETCH
//   ctrl_o      every datapath enable / mux select for this state
// Unreachable encodings (13-15) produce an all-zero control word.
module multicycle_ctrl_decode
  import multicycle_control_pkg::*;
(
  input  logic [3:0] state_i,
  input  logic       mem_ready_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read  = 1'b1;
        ctrl_o.alu_src_b = SRCB_FOUR;
        // Latch the instruction and advance PC only once the read completes
        ctrl_o.ir_write  = mem_ready_i;
        ctrl_o.pc_write  = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alu_src_b = SRCB_IMM_SH2;
      end
      ST_MADDR: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      ST_MREAD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      ST_MWB: begin
        ctrl_o.reg_write  = 1'b1;
        ctrl_o.mem_to_reg = 1'b1;
      end
      ST_MWRITE: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      ST_EXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_op    = ALUOP_FUNCT;
      end
      ST_RWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.reg_dst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alu_src_a     = 1'b1;
        ctrl_o.alu_op        = ALUOP_SUB;
        ctrl_o.pc_write_cond = 1'b1;
        ctrl_o.pc_source     = PCSRC_ALUOUT;
      end
      ST_JUMP: begin
        ctrl_o.pc_write  = 1'b1;
        ctrl_o.pc_source = PCSRC_JUMP;
      end
      ST_IEXEC: begin
        ctrl_o.alu_src_a = 1'b1;
        ctrl_o.alu_src_b = SRCB_IMM;
      end
      ST_IWB: begin
        ctrl_o.reg_write = 1'b1;
      end
      ST_TRAP: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle CPU control sequencer (Moore FSM).
// Steps each instruction through FETCH/DECODE/execute/memory/write-back,
// waits on the shared memory's ready in FETCH, MREAD and MWRITE, counts
// retired instructions and parks in TRAP on unsupported opcodes.
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   op_i              instruction opcode (used in DECODE and MADDR)
//   memReady_i        shared memory completed the current access
//   *_o controls      datapath enables and mux selects
//   state_o           current state encoding (debug)
//   illegal_o         high while trapped
//   instret_o         retired-instruction count (wraps)
// Handshake: memReady_i is a single-cycle completion strobe; the memory
// request (memRead_o/memWrite_o) is held for every wait cycle and the
// access is considered done only in the cycle memReady_i is 1.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int RETIRE_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [5:0]          op_i,
  input  logic                memReady_i,
  output logic                pcWrite_o,
  output logic                pcWriteCond_o,
  output logic                irWrite_o,
  output logic                regWrite_o,
  output logic                memRead_o,
  output logic                memWrite_o,
  output logic                iorD_o,
  output logic                regDst_o,
  output logic                memToReg_o,
  output logic                aluSrcA_o,
  output logic [1:0]          aluSrcB_o,
  output logic [1:0]          aluOp_o,
  output logic [1:0]          pcSource_o,
  output logic [3:0]          state_o,
  output logic                illegal_o,
  output logic [RETIRE_W-1:0] instret_o
);

  localparam logic [RETIRE_W-1:0] ONE = {{(RETIRE_W-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic [RETIRE_W-1:0] instret_q, instret_d;
  logic                retire;
  ctrl_t               ctrl;

  // Next-state and retirement
  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH:  if (memReady_i) state_d = ST_DECODE;
      ST_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_d = ST_MADDR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_IEXEC;
          default:      state_d = ST_TRAP;
        endcase
      end
      ST_MADDR:  state_d = (op_i == OP_LW) ? ST_MREAD : ST_MWRITE;
      ST_MREAD:  if (memReady_i) state_d = ST_MWB;
      ST_MWB:    state_d = ST_FETCH;
      ST_MWRITE: begin
        if (memReady_i) begin
          state_d = ST_FETCH;
          retire  = 1'b1;
        end
      end
      ST_EXEC:   state_d = ST_RWB;
      ST_RWB:    state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      ST_IEXEC:  state_d = ST_IWB;
      ST_IWB:    state_d = ST_FETCH;
      ST_TRAP:   state_d = ST_TRAP;
      // Encodings 13-15 are never entered legitimately; treat as a fault
      default:   state_d = ST_TRAP;
    endcase
    if (retires_on_exit(state_q)) retire = 1'b1;
    instret_d = retire ? (instret_q + ONE) : instret_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  multicycle_ctrl_decode u_decode (
    .state_i     (state_q),
    .mem_ready_i (memReady_i),
    .ctrl_o      (ctrl)
  );

  // Committing enables are suppressed while reset is held so an abandoned
  // instruction cannot write anything in the reset cycle.
  assign pcWrite_o     = ctrl.pc_write      & ~rst_i;
  assign pcWriteCond_o = ctrl.pc_write_cond & ~rst_i;
  assign irWrite_o     = ctrl.ir_write      & ~rst_i;
  assign regWrite_o    = ctrl.reg_write     & ~rst_i;
  assign memWrite_o    = ctrl.mem_write     & ~rst_i;
  assign memRead_o     = ctrl.mem_read;
  assign iorD_o        = ctrl.iord;
  assign regDst_o      = ctrl.reg_dst;
  assign memToReg_o    = ctrl.mem_to_reg;
  assign aluSrcA_o     = ctrl.alu_src_a;
  assign aluSrcB_o     = ctrl.alu_src_b;
  assign aluOp_o       = ctrl.alu_op;
  assign pcSource_o    = ctrl.pc_source;
  assign illegal_o     = ctrl.illegal;
  assign state_o       = state_q;
  assign instret_o     = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. A reference model expands
// each instruction into its expected state trace (with memory wait cycles)
// and expected control word per cycle, and tracks the retirement count.
module tb_multicycle_control;

  localparam int RW = 4;  // small counter so wrap-around is exercised

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [5:0]    op_i;
  logic          memReady_i;
  logic          pcWrite_o, pcWriteCond_o, irWrite_o, regWrite_o;
  logic          memRead_o, memWrite_o, iorD_o, regDst_o, memToReg_o;
  logic          aluSrcA_o, illegal_o;
  logic [1:0]    aluSrcB_o, aluOp_o, pcSource_o;
  logic [3:0]    state_o;
  logic [RW-1:0] instret_o;

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  multicycle_control #(.RETIRE_W(RW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .op_i(op_i), .memReady_i(memReady_i),
    .pcWrite_o(pcWrite_o), .pcWriteCond_o(pcWriteCond_o),
    .irWrite_o(irWrite_o), .regWrite_o(regWrite_o),
    .memRead_o(memRead_o), .memWrite_o(memWrite_o), .iorD_o(iorD_o),
    .regDst_o(regDst_o), .memToReg_o(memToReg_o), .aluSrcA_o(aluSrcA_o),
    .aluSrcB_o(aluSrcB_o), .aluOp_o(aluOp_o), .pcSource_o(pcSource_o),
    .state_o(state_o), .illegal_o(illegal_o), .instret_o(instret_o)
  );

  // ---------------- scoreboard ----------------
  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_instret = 0;
  logic [3:0] exp_q[$];   // expected state per cycle of the current instruction
  bit         rdy_q[$];   // memReady_i to drive per cycle

  logic [16:0] dut_ctrl;
  assign dut_ctrl = {pcWrite_o, pcWriteCond_o, irWrite_o, regWrite_o,
                     memRead_o, memWrite_o, iorD_o, regDst_o, memToReg_o,
                     aluSrcA_o, aluSrcB_o, aluOp_o, pcSource_o, illegal_o};

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected control word for a state, taken from the state/output table
  function automatic logic [16:0] exp_ctrl(input int st, input bit rdy, input bit rst);
    logic pcw, pcwc, irw, regw, memrd, memw, iord, rdst, m2r, srca, ill;
    logic [1:0] srcb, aop, psrc;
    pcw = 0; pcwc = 0; irw = 0; regw = 0; memrd = 0; memw = 0; iord = 0;
    rdst = 0; m2r = 0; srca = 0; ill = 0; srcb = 2'b00; aop = 2'b00; psrc = 2'b00;
    case (st)
      0:  begin memrd = 1; srcb = 2'b01; irw = rdy; pcw = rdy; end
      1:  srcb = 2'b11;
      2:  begin srca = 1; srcb = 2'b10; end
      3:  begin memrd = 1; iord = 1; end
      4:  begin regw = 1; m2r = 1; end
      5:  begin memw = 1; iord = 1; end
      6:  begin srca = 1; aop = 2'b10; end
      7:  begin regw = 1; rdst = 1; end
      8:  begin srca = 1; aop = 2'b01; pcwc = 1; psrc = 2'b01; end
      9:  begin pcw = 1; psrc = 2'b10; end
      10: begin srca = 1; srcb = 2'b10; end
      11: regw = 1;
      12: ill = 1;
      default: ;
    endcase
    if (rst) begin pcw = 0; pcwc = 0; irw = 0; regw = 0; memw = 0; end
    return {pcw, pcwc, irw, regw, memrd, memw, iord, rdst, m2r, srca,
            srcb, aop, psrc, ill};
  endfunction

  // ---------------- reference model: instruction -> trace ----------------
  task automatic push_wait(input int st, input int w);
    for (int k = 0; k < w; k++) begin exp_q.push_back(st[3:0]); rdy_q.push_back(1'b0); end
    exp_q.push_back(st[3:0]); rdy_q.push_back(1'b1);
  endtask

  // memReady_i is randomized where it must have no effect
  task automatic push_plain(input int st);
    exp_q.push_back(st[3:0]);
    rdy_q.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic build_trace(input logic [5:0] op, input int fw, input int mw,
                             output bit legal);
    exp_q.delete();
    rdy_q.delete();
    legal = 1'b1;
    push_wait(0, fw);
    push_plain(1);
    case (op)
      6'b000000: begin push_plain(6); push_plain(7); end
      6'b100011: begin push_plain(2); push_wait(3, mw); push_plain(4); end
      6'b101011: begin push_plain(2); push_wait(5, mw); end
      6'b000100: push_plain(8);
      6'b000010: push_plain(9);
      6'b001000: begin push_plain(10); push_plain(11); end
      default: begin
        legal = 1'b0;
        for (int k = 0; k < 12; k++) push_plain(12);
      end
    endcase
  endtask

  // ---------------- driver ----------------
  // Entered and left just after a rising edge. rst_at >= 0 asserts reset on
  // that trace cycle; -2 picks a random cycle. Illegal opcodes always end in
  // a reset on their last trace cycle.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input int rst_at_in);
    bit legal;
    int n;
    int rst_at;
    build_trace(op, fw, mw, legal);
    n = exp_q.size();
    rst_at = rst_at_in;
    if (rst_at == -2) rst_at = $urandom_range(0, n - 1);
    if (!legal && rst_at < 0) rst_at = n - 1;
    for (int i = 0; i < n; i++) begin
      rst_i      = (i == rst_at);
      memReady_i = rdy_q[i];
      op_i       = (exp_q[i] == 4'd0) ? 6'($urandom) : op;
      @(negedge clk_i);
      check("state", 32'(state_o), 32'(exp_q[i]));
      check("ctrl", 32'(dut_ctrl), 32'(exp_ctrl(int'(exp_q[i]), rdy_q[i], rst_i)));
      check("instret", 32'(instret_o), 32'(exp_instret));
      @(posedge clk_i);
      #1;
      if (i == rst_at) begin
        rst_i = 1'b0;
        exp_instret = 0;
        return;
      end
    end
    if (legal) exp_instret = (exp_instret + 1) % (1 << RW);
  endtask

  function automatic logic [5:0] rand_legal_op();
    case ($urandom_range(0, 5))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b000010;
      default: return 6'b001000;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_i = 1'b1;
    memReady_i = 1'b1;
    op_i = 6'b000000;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    // Reset held: FETCH, counter cleared, enables forced low despite ready=1
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_instret", 32'(instret_o), 32'd0);
    check("rst_ctrl", 32'(dut_ctrl), 32'(exp_ctrl(0, 1'b1, 1'b1)));
    @(posedge clk_i); #1;
    rst_i = 1'b0;

    // Directed sequence
    run_instr(6'b000000, 0, 0, -1);   // R-type
    run_instr(6'b100011, 0, 2, -1);   // LW with 2 wait cycles in MREAD
    run_instr(6'b101011, 0, 0, -1);   // SW
    run_instr(6'b000100, 0, 0, -1);   // BEQ
    run_instr(6'b000010, 0, 0, -1);   // J
    run_instr(6'b001000, 3, 0, -1);   // ADDI after 3 FETCH wait cycles
    run_instr(6'b101011, 0, 3, -1);   // SW with MWRITE waits
    run_instr(6'b111111, 0, 0, -1);   // illegal -> TRAP, then reset
    run_instr(6'b100011, 0, 3, 4);    // reset mid MREAD wait
    run_instr(6'b000000, 1, 0, -1);   // normal operation resumes

    // Long reset-free run so the counter wraps
    for (int k = 0; k < 20; k++)
      run_instr(rand_legal_op(), $urandom_range(0, 2), $urandom_range(0, 3), -1);

    // Mixed random: occasional illegal opcodes and random resets
    for (int k = 0; k < 40; k++) begin
      logic [5:0] op;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : rand_legal_op();
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? -2 : -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Moore-style sequencer that drives the CPU datapath in a multi-cycle schedule (fetch, decode, execute, memory, write-back), so one ALU and one shared instruction/data memory serve every instruction. It sits beside `Control` and `ALUControl`: it consumes the opcode field of the instruction register and emits every datapath enable and mux select. It also handles a ready handshake from the shared memory, counts retired instructions, and traps on unsupported opcodes.

## Interface
- `RETIRE_W`, default 32: width of the retired-instruction counter.
- `clk_i`  in  1  single clock; all state updates on the rising edge.
- `rst_i`  in  1  synchronous, active-high reset.
- `op_i`  in  6  opcode field of the instruction register, valid from DECODE onward.
- `memReady_i`  in  1  shared memory has completed the current read or write this cycle.
- `pcWrite_o`, `pcWriteCond_o`, `irWrite_o`, `regWrite_o`, `memRead_o`, `memWrite_o`  out  1 each  datapath enables.
- `iorD_o`  out  1  memory address select: 0 = PC, 1 = ALU output register.
- `regDst_o`  out  1  write-address select: 0 = RT, 1 = RD.
- `memToReg_o`  out  1  write-data select: 0 = ALU output, 1 = memory data register.
- `aluSrcA_o`  out  1  ALU A select: 0 = PC, 1 = register A.
- `aluSrcB_o`  out  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- `aluOp_o`  out  2  to `ALUControl`: 00 = add, 01 = subtract, 10 = use funct.
- `pcSource_o`  out  2  next-PC select: 00 = ALU result, 01 = ALU output register, 10 = jump target.
- `state_o`  out  4  current state encoding, for debug.
- `illegal_o`  out  1  high while in TRAP.
- `instret_o`  out  RETIRE_W  retired-instruction count.

## Operation
- Supported opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000.
- States and encodings, with the outputs each state asserts (anything not listed is 0):
  - FETCH 0: memRead, aluSrcB=01. irWrite and pcWrite are asserted only in the cycle where memReady_i=1. Stays in FETCH until memReady_i=1, then goes to DECODE.
  - DECODE 1: aluSrcB=11. Next state by op_i: LW or SW go to MADDR, R-type to EXEC, BEQ to BRANCH, J to JUMP, ADDI to IEXEC, any other opcode to TRAP.
  - MADDR 2: aluSrcA=1, aluSrcB=10. Goes to MREAD if op_i is LW, otherwise to MWRITE.
  - MREAD 3: memRead, iorD. Stays until memReady_i=1, then goes to MWB.
  - MWB 4: regWrite, memToReg. Goes to FETCH.
  - MWRITE 5: memWrite, iorD. Stays until memReady_i=1, then goes to FETCH.
  - EXEC 6: aluSrcA=1, aluOp=10. Goes to RWB.
  - RWB 7: regWrite, regDst. Goes to FETCH.
  - BRANCH 8: aluSrcA=1, aluOp=01, pcWriteCond, pcSource=01. Goes to FETCH.
  - JUMP 9: pcWrite, pcSource=10. Goes to FETCH.
  - IEXEC 10: aluSrcA=1, aluSrcB=10. Goes to IWB.
  - IWB 11: regWrite. Goes to FETCH.
  - TRAP 12: illegal_o=1. Stays in TRAP until rst_i.
- Encodings 13–15 are unreachable. If entered, the FSM goes to TRAP on the next cycle.
- Retirement: instret_o increments by 1, wrapping modulo 2^RETIRE_W, on leaving MWB, RWB, BRANCH, JUMP or IWB, and on leaving MWRITE with memReady_i=1.
- memWrite_o stays high for every MWRITE wait cycle. The memory must commit only once, in the cycle where it asserts memReady_i.

## Timing
- Control outputs are combinational from the state register (Moore), with no input-to-output paths except:
  - memReady_i gates irWrite_o and pcWrite_o in FETCH;
  - op_i selects the next state.
- Minimum cycles with memReady_i held at 1: BEQ 3, J 3, R-type 4, ADDI 4, SW 4, LW 5. Each cycle memReady_i is low adds 1 cycle in FETCH, MREAD or MWRITE.
- Reset: the cycle after rst_i is sampled high, state_o=0 (FETCH), instret_o=0, illegal_o=0.
- While rst_i=1, pcWrite_o, pcWriteCond_o, irWrite_o, regWrite_o and memWrite_o are forced to 0.
- Reset mid-instruction, including during a memory wait: the instruction is abandoned, nothing is committed, and no retirement is counted.
- memReady_i has no effect in states other than FETCH, MREAD and MWRITE.

## Structure
- Shared package holds: the opcode constants, the state enum (4-bit encodings as listed above), and the aluSrcB, aluOp and pcSource encodings. `ALUControl` imports the same aluOp values.
- The state-to-controls decode is a natural pure-combinational sub-module, `multicycle_ctrl_decode`.
- The next-state logic, the state register and the retirement counter stay in the top module.

## Test plan
- Reset, then R-type (op 000000) with memReady_i=1 → states 0,1,6,7,0. regWrite_o=1 and regDst_o=1 only in state 7. instret_o becomes 1.
- LW (100011) with memReady_i low for 2 cycles in MREAD → states 0,1,2,3,3,3,4,0. memToReg_o=1 in state 4. 7 cycles total.
- SW (101011), then BEQ (000100), then J (000010) → memWrite_o only in state 5; pcWriteCond_o with pcSource_o=01 in state 8; pcWrite_o with pcSource_o=10 in state 9. instret_o increases by 3.
- FETCH with memReady_i=0 for 3 cycles → irWrite_o and pcWrite_o stay 0 for those cycles and pulse for exactly 1 cycle when ready rises.
- Opcode 111111 in DECODE → state 12 and illegal_o=1 for 10+ cycles. instret_o unchanged. rst_i returns state to 0.
- rst_i asserted in state 3 mid-wait → next cycle state 0, instret_o=0, and no regWrite_o pulse.
